// File: rtl/ul4_secuenciador.sv
// Operand sequencer and result register around the 4-bit logic unit:
// accepts a command, holds operands for SETTLE cycles, captures and presents the result.
module ul4_secuenciador #(
    parameter int W      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_s,
    input  logic             in_chain,
    output logic [W-1:0]     ul_a,
    output logic [W-1:0]     ul_b,
    output logic [1:0]       ul_s,
    input  logic [W-1:0]     ul_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] settle_cnt;
    logic            accept;
    logic            capture;
    logic            consume;

    assign accept  = in_valid && in_ready;
    assign capture = (state == ST_WAIT) && (settle_cnt == '0);
    assign consume = (state == ST_HOLD) && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)  state_nxt = ST_WAIT;
            ST_WAIT: if (capture) state_nxt = ST_HOLD;
            ST_HOLD: if (consume) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // in_ready is gated by reset so nothing is offered while the block is held in reset
    always_comb begin
        in_ready  = (state == ST_IDLE) && reset;
        out_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ul_a       <= '0;
            ul_b       <= '0;
            ul_s       <= '0;
            settle_cnt <= '0;
            out_res    <= '0;
            out_zero   <= 1'b1;
        end else begin
            if (accept) begin
                ul_a       <= in_chain ? out_res : in_a;
                ul_b       <= in_b;
                ul_s       <= in_s;
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == ST_WAIT) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SC_W'(1);
            end
            if (capture) begin
                out_res  <= ul_out;
                out_zero <= (ul_out == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count <= '0;
        end else if (consume) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ul4_secuenciador.sv
// Self-checking bench for ul4_secuenciador with a behavioural logic-unit model
// and a transaction-level reference for results, chaining and the op counter.
module tb_ul4_secuenciador;

    localparam int W      = 4;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [1:0]       in_s;
    logic             in_chain;
    logic [W-1:0]     ul_a;
    logic [W-1:0]     ul_b;
    logic [1:0]       ul_s;
    logic [W-1:0]     ul_out;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    logic             out_zero;
    logic [CNT_W-1:0] op_count;

    int total;
    int bad;
    int m_res;
    int m_cnt;

    ul4_secuenciador #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_chain(in_chain),
        .ul_a(ul_a), .ul_b(ul_b), .ul_s(ul_s), .ul_out(ul_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_zero(out_zero), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lu(input int a, input int b, input int s);
        case (s)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return (~a) & 15;
        endcase
    endfunction

    // Logic unit under the sequencer
    assign ul_out = W'(lu(int'(ul_a), int'(ul_b), int'(ul_s)));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int a, input int b, input int s, input int ch);
        in_valid = 1'b1;
        in_a     = W'(a);
        in_b     = W'(b);
        in_s     = 2'(s);
        in_chain = ch[0];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; in_chain = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        total++; if (out_res !== 4'h0) begin bad++; $display("FAIL reset_out_res: got %0h expected 0", out_res); end
        total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL reset_out_zero: got %0b expected 1", out_zero); end
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        total++; if (ul_a !== 4'h0) begin bad++; $display("FAIL reset_ul_a: got %0h expected 0", ul_a); end
        reset = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %0b expected 1", in_ready); end
        m_res = 0;
        m_cnt = 0;
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        drive_cmd(5, 3, 2, 0);
        tick();
        in_valid = 1'b0;
        total++; if (ul_a !== 4'h5) begin bad++; $display("FAIL single_ul_a: got %0h expected 5", ul_a); end
        total++; if (ul_b !== 4'h3) begin bad++; $display("FAIL single_ul_b: got %0h expected 3", ul_b); end
        total++; if (ul_s !== 2'd2) begin bad++; $display("FAIL single_ul_s: got %0d expected 2", ul_s); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %0b expected 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_wait_ready: got %0b expected 0", in_ready); end
        tick();
        m_res = lu(5, 3, 2);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
        total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL single_res: got %0h expected %0h", out_res, m_res); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL single_zero: got %0b expected 0", out_zero); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_cnt = (m_cnt + 1) % 256;
        total++; if (op_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL single_count: got %0d expected %0d", op_count, m_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid: got %0b expected 0", out_valid); end
        total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL single_retain: got %0h expected %0h", out_res, m_res); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_idle_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_cmd(5, 3, 2, 0);
        tick();
        in_valid = 1'b0;
        tick();
        m_res = lu(5, 3, 2);
        // a competing command sits on the input throughout HOLD and into the handshake
        drive_cmd(9, 6, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %0b expected 1", i, out_valid); end
            total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL bp_res[%0d]: got %0h expected %0h", i, out_res, m_res); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0b expected 0", i, in_ready); end
            total++; if (op_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL bp_count[%0d]: got %0d expected %0d", i, op_count, m_cnt); end
            total++; if (ul_a !== 4'h5) begin bad++; $display("FAIL bp_ul_a[%0d]: got %0h expected 5", i, ul_a); end
        end
        out_ready = 1'b1;
        tick();
        m_cnt = (m_cnt + 1) % 256;
        total++; if (op_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL bp_release_count: got %0d expected %0d", op_count, m_cnt); end
        total++; if (ul_a !== 4'h5) begin bad++; $display("FAIL bp_no_accept_on_handshake: got %0h expected 5", ul_a); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready: got %0b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (ul_a !== 4'h9 || ul_b !== 4'h6) begin bad++; $display("FAIL bp_late_accept: got %0h/%0h expected 9/6", ul_a, ul_b); end
        tick();
        m_res = lu(9, 6, 1);
        total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL bp_late_res: got %0h expected %0h", out_res, m_res); end
        tick();
        m_cnt = (m_cnt + 1) % 256;
        out_ready = 1'b0;
        total++; if (op_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL bp_late_count: got %0d expected %0d", op_count, m_cnt); end
    endtask

    task automatic test_chain();
        out_ready = 1'b1;
        drive_cmd(12, 10, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        m_res = lu(12, 10, 0);
        total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL chain_first_res: got %0h expected %0h", out_res, m_res); end
        tick();
        m_cnt = (m_cnt + 1) % 256;
        drive_cmd(3, 8, 2, 1);
        tick();
        in_valid = 1'b0;
        in_chain = 1'b0;
        total++; if (ul_a !== W'(m_res)) begin bad++; $display("FAIL chain_ul_a: got %0h expected %0h", ul_a, m_res); end
        tick();
        m_res = lu(m_res, 8, 2);
        total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL chain_res: got %0h expected %0h", out_res, m_res); end
        total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL chain_zero: got %0b expected 1", out_zero); end
        tick();
        m_cnt = (m_cnt + 1) % 256;
        total++; if (op_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL chain_count: got %0d expected %0d", op_count, m_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        out_ready = 1'b0;
        drive_cmd(15, 0, 1, 0);
        tick();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b expected 0", out_valid); end
        total++; if (out_res !== 4'h0) begin bad++; $display("FAIL midrst_res: got %0h expected 0", out_res); end
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL midrst_count: got %0d expected 0", op_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %0b expected 0", in_ready); end
        tick();
        reset = 1'b1;
        m_res = 0;
        m_cnt = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready: got %0b expected 1", in_ready); end
        drive_cmd(3, 5, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        m_res = lu(3, 5, 0);
        total++; if (out_res !== W'(m_res) || out_valid !== 1'b1) begin bad++; $display("FAIL midrst_next_res: got %0h/%0b expected %0h/1", out_res, out_valid, m_res); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_cnt = (m_cnt + 1) % 256;
        total++; if (op_count !== CNT_W'(m_cnt)) begin bad++; $display("FAIL midrst_next_count: got %0d expected %0d", op_count, m_cnt); end
    endtask

    task automatic test_back_to_back_wrap();
        int a, b, s, ch, opa;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_res = 0;
        m_cnt = 0;
        out_ready = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            s  = int'($urandom_range(0, 3));
            ch = int'($urandom_range(0, 1));
            opa = (ch != 0) ? m_res : a;
            drive_cmd(a, b, s, ch);
            tick();
            in_valid = 1'b0;
            tick();
            m_res = lu(opa, b, s);
            if ((k % 16) == 0 || k == 1) begin
                total++; if (out_res !== W'(m_res)) begin bad++; $display("FAIL wrap_res[%0d]: got %0h expected %0h", k, out_res, m_res); end
                total++; if (out_zero !== (m_res == 0)) begin bad++; $display("FAIL wrap_zero[%0d]: got %0b expected %0b", k, out_zero, m_res == 0); end
            end else if (out_res !== W'(m_res)) begin
                total++; bad++; $display("FAIL wrap_res[%0d]: got %0h expected %0h", k, out_res, m_res);
            end
            tick();
            m_cnt = (m_cnt + 1) % 256;
            if (k == 255) begin
                total++; if (op_count !== 8'd255) begin bad++; $display("FAIL wrap_count_255: got %0d expected 255", op_count); end
            end else if (k == 256) begin
                total++; if (op_count !== 8'd0) begin bad++; $display("FAIL wrap_count_256: got %0d expected 0", op_count); end
            end else if (op_count !== CNT_W'(m_cnt)) begin
                total++; bad++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, op_count, m_cnt);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_res = 0;
        m_cnt = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_chain();
        test_reset_mid_wait();
        test_back_to_back_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ul4_secuenciador.md
Name: ul4_secuenciador

Overview:
- Operand sequencer and result register placed around the 4-bit logic unit `cl`.
- Upstream: accepts an operation command (a, b, s) through a valid/ready handshake and drives the unit's inputs.
- Waits a fixed settle time, then captures the unit's output with a zero flag and presents it downstream through a valid/ready handshake.
- Supports chaining, where the previous result is used as operand a, and counts completed operations.

Parameters:
- W, 4: operand/result width; must equal the logic unit width.
- SETTLE, 1: cycles the operands are held on ul_* before capture; legal values are 1 or more.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 means in reset.
- in_valid  in  1  a command is present on in_a/in_b/in_s/in_chain.
- in_ready  out  1  the sequencer accepts a command this cycle.
- in_a  in  W  operand a.
- in_b  in  W  operand b.
- in_s  in  2  operation select passed to the logic unit.
- in_chain  in  1  1 means use the last captured result instead of in_a.
- ul_a  out  W  operand a to the logic unit.
- ul_b  out  W  operand b to the logic unit.
- ul_s  out  2  select to the logic unit.
- ul_out  in  W  result from the logic unit.
- out_valid  out  1  out_res/out_zero hold a valid result.
- out_ready  in  1  the downstream consumer takes the result.
- out_res  out  W  captured result.
- out_zero  out  1  1 when out_res == 0.
- op_count  out  CNT_W  number of results consumed downstream, modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE.
  - Operand registers (ul_a, ul_b, ul_s) = 0.
  - res = 0, out_zero = 1, out_valid = 0, op_count = 0, settle counter = 0.
  - in_ready = 0 while reset = 0.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - in_ready = 1.
  - On the edge with in_valid & in_ready:
    - Latch ul_a = in_chain ? res : in_a; ul_b = in_b; ul_s = in_s.
    - Load settle counter = SETTLE - 1; go to WAIT.
  - With in_valid = 0, stay in IDLE.
- WAIT:
  - in_ready = 0; in_valid and in_* are ignored.
  - If the counter is nonzero, decrement it on each edge.
  - On the edge where the counter is 0:
    - res <= ul_out, out_zero <= (ul_out == 0).
    - Go to HOLD.
- HOLD:
  - out_valid = 1; in_ready = 0.
  - On the edge with out_ready = 1: go to IDLE and increment op_count (wraps 2^CNT_W - 1 -> 0).
  - With out_ready = 0, stay in HOLD; out_res and out_zero are held stable.
- ul_a, ul_b, ul_s:
  - Driven only from registers, so glitch-free.
  - Change only on the accept edge.
  - Hold their value in every other state, including IDLE after completion.
- out_res and out_zero:
  - Always reflect the registered result.
  - Retain the last result after the HOLD handshake.
- out_valid is decoded from the state (HOLD only).
- Latency: out_valid rises SETTLE clock edges after the accept edge. With SETTLE = 1: accept at edge k, capture at edge k+1, out_valid high from k+1.
- Throughput: at most one command per SETTLE + 2 cycles (IDLE occupies one cycle). There is no overlap of accept and handshake.
- Chain with no prior result uses res = 0.
- out_ready while not in HOLD is ignored.
- Simultaneous events: in_valid asserted in the same cycle as the HOLD handshake is not accepted; it is accepted on the following IDLE cycle.
- Reset mid-operation (WAIT or HOLD):
  - Immediate return to IDLE with all reset values.
  - The pending command and result are lost; op_count clears.

Test Plan:
Bench models the logic unit as s = 00 AND, 01 OR, 10 XOR, 11 NOT a, with SETTLE = 1 and CNT_W = 8.
1. Reset: hold reset = 0 for 3 cycles -> out_valid = 0, out_res = 0000, out_zero = 1, op_count = 0, in_ready = 0. After release -> in_ready = 1.
2. Single op: a = 0101, b = 0011, s = 10, in_valid pulse -> ul_a = 0101 and ul_b = 0011 from the accept edge; out_valid one edge later with out_res = 0110, out_zero = 0. With out_ready = 1 -> op_count = 1.
3. Backpressure: same op with out_ready = 0 for 5 cycles -> out_valid stays 1, out_res stable, in_ready = 0. A new in_valid during HOLD is ignored and op_count is unchanged. Raising out_ready -> IDLE, op_count + 1.
4. Chain: a = 1100, b = 1010, s = 00 -> out_res = 1000. Then in_chain = 1, b = 1000, s = 10 -> ul_a = 1000, out_res = 0000, out_zero = 1.
5. Reset mid-WAIT: assert reset = 0 in the WAIT cycle -> out_valid = 0, res = 0000, op_count = 0. After release -> IDLE, in_ready = 1, next command completes normally.
6. Counter wrap: 256 back-to-back ops with out_ready = 1 -> op_count reads 255 after op 255, then 0 after op 256.
